output_flow: RTL and testbench
==============================

# output_flow

Egress flow-control block on the far side of the virtual-channel FIFOs. It pops words from the two VC FIFOs, vc0 and vc1, and routes each word to destination FIFO D0 or D1 according to a destination bit carried in the word. It honours the destinations' pause (almost-full) flags and gives vc0 strict priority, with a bounded-burst guard so vc1 cannot starve. Per-destination push counters are kept for verification and statistics.

## Interface

**Parameters**

- DATA_WIDTH, 6: word width of the VC and destination FIFOs.
- DEST_BIT, 4: bit index of the word that selects the destination (0 = D0, 1 = D1).
- BURST_MAX, 4: maximum consecutive vc0 pops while vc1 is non-empty.
- CNT_WIDTH, 8: width of the push counters.

**Ports**

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- vc0_empty  in  1  vc0 FIFO empty.
- vc1_empty  in  1  vc1 FIFO empty.
- vc0_data  in  DATA_WIDTH  vc0 read data, valid the cycle after pop_vc0.
- vc1_data  in  DATA_WIDTH  vc1 read data, valid the cycle after pop_vc1.
- d0_pause  in  1  D0 almost-full; at least 3 free slots remain when it asserts.
- d1_pause  in  1  D1 almost-full; same margin as D0.
- pop_vc0  out  1  combinational pop strobe to vc0.
- pop_vc1  out  1  combinational pop strobe to vc1.
- push_d0  out  1  registered push strobe to D0.
- push_d1  out  1  registered push strobe to D1.
- data_d0  out  DATA_WIDTH  registered write data to D0.
- data_d1  out  DATA_WIDTH  registered write data to D1.
- d0_count  out  CNT_WIDTH  saturating count of D0 pushes.
- d1_count  out  CNT_WIDTH  saturating count of D1 pushes.
- idle  out  1  high when in IDLE state with no word in flight.

## Operation

**Reset values.** Every output is 0 while reset is high, except idle, which is 1. Pipeline state and counters are cleared. Pops are forced to 0 asynchronously.

**FSM states.** The FSM has three states:
- RESET: entered asynchronously on reset. Moves to IDLE on the first edge after reset releases.
- IDLE: moves to ACTIVE in any cycle where a pop is issued.
- ACTIVE: returns to IDLE when no pop is issued and the pipeline is empty.

**Eligibility.** A pop can issue only when all of the following hold:
- state is IDLE or ACTIVE;
- d0_pause is 0 and d1_pause is 0, since the destination is unknown before the pop;
- at least one VC is non-empty.

**Arbitration.**
- When eligible, pop vc0 if it is non-empty; otherwise pop vc1.
- Exception: if burst_cnt == BURST_MAX and vc1 is non-empty, pop vc1 instead.
- At most one pop per cycle; pop_vc0 and pop_vc1 are never high together.

**burst_cnt** (width clog2(BURST_MAX+1)):
- increments on each vc0 pop while vc1_empty is 0;
- clears on a vc1 pop, or on any cycle with vc1_empty high;
- never exceeds BURST_MAX.

**Routing.** The registered pop select chooses between vc0_data and vc1_data. Bit DEST_BIT of the selected word chooses push_d0/data_d0 or push_d1/data_d1. The unused data output holds its previous value.

**Counters.** A destination counter increments on the edge that ends a cycle in which its push strobe is high. Counters saturate at all ones and never wrap.

## Timing

- Cycle t: pop_vcX = 1.
- Edge ending t: sel_q and vld_q are registered.
- Cycle t+1: the selected vcX_data is sampled.
- Edge ending t+1: push_dX and data_dX are registered.
- Latency is 2 cycles from pop to push, with one pop per cycle sustained throughput.
- Up to 2 words are in flight, which the 3-slot pause margin covers. In-flight words always complete, even if pause asserts.
- Pause sampled high in cycle t means no pop in cycle t; pops resume in the first cycle pause is low.
- A pop with the FIFO empty is impossible: the pop is gated by vcX_empty in the same cycle.
- Reset asserted mid-operation: in-flight words are discarded, with no push after reset asserts.
- Counter saturation at all ones: pushes still occur; the count holds at all ones.

## Structure

- Shared package output_flow_pkg holds:
  - FSM state encoding (RESET=2'd0, IDLE=2'd1, ACTIVE=2'd2);
  - default DEST_BIT;
  - VC select encoding (VC0=1'b0, VC1=1'b1).
- One sub-module, output_arbiter, contains the eligibility check, the priority/burst selection and burst_cnt, and outputs the pop strobes plus the select.
- The top level holds the FSM, the two-stage pipeline, the routing and the counters.

## Test plan

- Reset with both VCs holding data -> all pops, pushes and counts are 0 and idle = 1. After release, the first pop_vc0 occurs in the cycle after the FSM leaves RESET.
- vc0 holds words 6'h10 then 6'h05, vc1 empty, no pause -> pops in cycles t and t+1. push_d1 with data_d1 = 6'h10 at t+2; push_d0 with data_d0 = 6'h05 at t+3. d1_count = 1 and d0_count = 1.
- Both VCs continuously non-empty, BURST_MAX = 4 -> pop pattern vc0, vc0, vc0, vc0, vc1, repeating.
- d0_pause raised in the cycle after two back-to-back pops -> both in-flight words are pushed, and no new pop occurs until pause drops.
- Reset asserted one cycle after a pop -> no push follows, and outputs return to reset values immediately.
- 260 words to D0 with CNT_WIDTH = 8 -> d0_count holds 8'hFF after the 255th push.

Source files
------------

// File: rtl/output_flow_pkg.sv
// output_flow_pkg
//   Shared definitions for the egress flow-control block:
//   - state_t  : FSM state encoding
//   - vc_sel_t : virtual-channel select encoding carried down the pipeline
//   - DEST_BIT_DEFAULT : default index of the destination bit in a word
package output_flow_pkg;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  typedef enum logic {
    VC0 = 1'b0,
    VC1 = 1'b1
  } vc_sel_t;

  localparam int DEST_BIT_DEFAULT = 4;

endpackage

// File: rtl/output_arbiter.sv
// output_arbiter
//   Decides which virtual channel (if any) to pop this cycle. vc0 has strict
//   priority, except that after BURST_MAX consecutive vc0 pops with vc1
//   waiting, one vc1 pop is forced so vc1 cannot starve.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   enable                 FSM is in a state that may pop
//   vc0_empty, vc1_empty   source FIFO empty flags
//   d0_pause, d1_pause     destination almost-full flags
//   pop_vc0, pop_vc1       combinational pop strobes (mutually exclusive)
//   sel                    VC selected this cycle (VC0/VC1), valid with a pop
module output_arbiter
  import output_flow_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic vc0_empty,
  input  logic vc1_empty,
  input  logic d0_pause,
  input  logic d1_pause,
  output logic pop_vc0,
  output logic pop_vc1,
  output logic sel
);

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_LIMIT = BW'(BURST_MAX);

  logic [BW-1:0] burst_cnt;
  logic          eligible;
  logic          force_vc1;

  always_comb begin
    // Both pauses gate the pop because the destination is only known once
    // the word has been read out of the VC FIFO.
    eligible  = enable && !reset && !d0_pause && !d1_pause &&
                !(vc0_empty && vc1_empty);
    force_vc1 = (burst_cnt == BURST_LIMIT) && !vc1_empty;
    pop_vc0   = eligible && !vc0_empty && !force_vc1;
    // Eligible with vc0 empty implies vc1 is non-empty; force_vc1 implies it too.
    pop_vc1   = eligible && (vc0_empty || force_vc1);
    sel       = pop_vc1 ? VC1 : VC0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_cnt <= '0;
    end else if (vc1_empty || pop_vc1) begin
      burst_cnt <= '0;
    end else if (pop_vc0 && (burst_cnt != BURST_LIMIT)) begin
      burst_cnt <= burst_cnt + BW'(1);
    end
  end

endmodule

// File: rtl/output_flow.sv
// output_flow
//   Egress flow control behind the VC FIFOs. Pops words from vc0/vc1 (via
//   output_arbiter), routes each to destination FIFO D0 or D1 by bit DEST_BIT
//   of the word, and keeps saturating per-destination push counters.
//   Pop-to-push latency is 2 cycles; one word per cycle sustained.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   vc0_empty, vc1_empty   VC FIFO empty flags
//   vc0_data, vc1_data     VC FIFO read data, valid the cycle after the pop
//   d0_pause, d1_pause     destination almost-full flags (>=3 free slots)
//   pop_vc0, pop_vc1       combinational pop strobes
//   push_d0, push_d1       registered push strobes
//   data_d0, data_d1       registered write data (hold when not pushed)
//   d0_count, d1_count     saturating push counters
//   idle                   IDLE (or RESET) state with no word in flight
module output_flow
  import output_flow_pkg::*;
#(
  parameter int DATA_WIDTH = 6,
  parameter int DEST_BIT   = DEST_BIT_DEFAULT,
  parameter int BURST_MAX  = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vc0_empty,
  input  logic                  vc1_empty,
  input  logic [DATA_WIDTH-1:0] vc0_data,
  input  logic [DATA_WIDTH-1:0] vc1_data,
  input  logic                  d0_pause,
  input  logic                  d1_pause,
  output logic                  pop_vc0,
  output logic                  pop_vc1,
  output logic                  push_d0,
  output logic                  push_d1,
  output logic [DATA_WIDTH-1:0] data_d0,
  output logic [DATA_WIDTH-1:0] data_d1,
  output logic [CNT_WIDTH-1:0]  d0_count,
  output logic [CNT_WIDTH-1:0]  d1_count,
  output logic                  idle
);

  state_t                state, state_next;
  logic                  enable;
  logic                  pop_any;
  logic                  sel;
  logic                  sel_p0;
  logic                  vld_p0;
  logic [DATA_WIDTH-1:0] word_p1;
  logic                  dest_p1;

  assign enable  = (state == ST_IDLE) || (state == ST_ACTIVE);
  assign pop_any = pop_vc0 || pop_vc1;

  output_arbiter #(
    .BURST_MAX (BURST_MAX)
  ) u_arbiter (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .vc0_empty (vc0_empty),
    .vc1_empty (vc1_empty),
    .d0_pause  (d0_pause),
    .d1_pause  (d1_pause),
    .pop_vc0   (pop_vc0),
    .pop_vc1   (pop_vc1),
    .sel       (sel)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RESET;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RESET:  state_next = ST_IDLE;
      ST_IDLE:   if (pop_any) state_next = ST_ACTIVE;
      ST_ACTIVE: if (!pop_any && !vld_p0) state_next = ST_IDLE;
      default:   state_next = ST_RESET;
    endcase
  end

  // RESET counts as idle so idle reads 1 while reset is held.
  assign idle = (state != ST_ACTIVE) && !vld_p0;

  // Stage p0: remember which VC was popped; its data arrives next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      sel_p0 <= VC0;
    end else begin
      vld_p0 <= pop_any;
      sel_p0 <= sel;
    end
  end

  always_comb begin
    word_p1 = (sel_p0 == VC1) ? vc1_data : vc0_data;
    dest_p1 = word_p1[DEST_BIT];
  end

  // Stage p1: route the read word to its destination.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_d0 <= 1'b0;
      push_d1 <= 1'b0;
      data_d0 <= '0;
      data_d1 <= '0;
    end else begin
      push_d0 <= vld_p0 && !dest_p1;
      push_d1 <= vld_p0 && dest_p1;
      if (vld_p0 && !dest_p1) data_d0 <= word_p1;
      if (vld_p0 && dest_p1)  data_d1 <= word_p1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d0_count <= '0;
      d1_count <= '0;
    end else begin
      if (push_d0 && (d0_count != '1)) d0_count <= d0_count + CNT_WIDTH'(1);
      if (push_d1 && (d1_count != '1)) d1_count <= d1_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_output_flow.sv
// tb_output_flow
//   Bench for output_flow: behavioural VC FIFOs feed the DUT, every popped
//   word is pushed onto a per-destination expected queue and compared when
//   the DUT pushes it out. Scenario tasks add cycle-exact checks.
module tb_output_flow;

  localparam int DW = 6;
  localparam int DB = 4;
  localparam int BM = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vc0_empty = 1'b1;
  logic          vc1_empty = 1'b1;
  logic [DW-1:0] vc0_data;
  logic [DW-1:0] vc1_data;
  logic          d0_pause = 1'b0;
  logic          d1_pause = 1'b0;
  logic          pop_vc0, pop_vc1, push_d0, push_d1, idle;
  logic [DW-1:0] data_d0, data_d1;
  logic [CW-1:0] d0_count, d1_count;

  int checks = 0;
  int passes = 0;
  int push0_seen = 0;
  int push1_seen = 0;

  logic [DW-1:0] vc0_q[$];
  logic [DW-1:0] vc1_q[$];
  logic [DW-1:0] exp_d0[$];
  logic [DW-1:0] exp_d1[$];
  int            pop_hist[$];

  output_flow #(
    .DATA_WIDTH (DW),
    .DEST_BIT   (DB),
    .BURST_MAX  (BM),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .vc0_empty (vc0_empty),
    .vc1_empty (vc1_empty),
    .vc0_data  (vc0_data),
    .vc1_data  (vc1_data),
    .d0_pause  (d0_pause),
    .d1_pause  (d1_pause),
    .pop_vc0   (pop_vc0),
    .pop_vc1   (pop_vc1),
    .push_d0   (push_d0),
    .push_d1   (push_d1),
    .data_d0   (data_d0),
    .data_d1   (data_d1),
    .d0_count  (d0_count),
    .d1_count  (d1_count),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  // VC FIFO model: data is presented the cycle after the pop.
  logic [DW-1:0] w0, w1;
  always @(posedge clk) begin
    if (pop_vc0 && pop_vc1) begin
      checks++;
      $display("FAIL both_pops got=11 exp=one-hot");
    end
    if (pop_vc0) begin
      if (vc0_q.size() == 0) begin
        checks++;
        $display("FAIL pop_vc0_on_empty got=1 exp=0");
      end else begin
        w0 = vc0_q.pop_front();
        vc0_data <= w0;
        pop_hist.push_back(0);
        if (w0[DB]) exp_d1.push_back(w0);
        else        exp_d0.push_back(w0);
      end
    end
    if (pop_vc1) begin
      if (vc1_q.size() == 0) begin
        checks++;
        $display("FAIL pop_vc1_on_empty got=1 exp=0");
      end else begin
        w1 = vc1_q.pop_front();
        vc1_data <= w1;
        pop_hist.push_back(1);
        if (w1[DB]) exp_d1.push_back(w1);
        else        exp_d0.push_back(w1);
      end
    end
  end

  // Empty flags follow the queue contents shortly after either clock edge.
  always @(posedge clk or negedge clk) begin
    #1;
    vc0_empty = (vc0_q.size() == 0);
    vc1_empty = (vc1_q.size() == 0);
  end

  // Scoreboard: compare each DUT push against the expected word.
  logic [DW-1:0] e0, e1;
  always @(negedge clk) begin
    if (push_d0) begin
      push0_seen++;
      checks++;
      if (exp_d0.size() == 0) begin
        $display("FAIL sb_d0_unexpected got=%h exp=none", data_d0);
      end else begin
        e0 = exp_d0.pop_front();
        if (data_d0 !== e0) $display("FAIL sb_d0_data got=%h exp=%h", data_d0, e0);
        else passes++;
      end
    end
    if (push_d1) begin
      push1_seen++;
      checks++;
      if (exp_d1.size() == 0) begin
        $display("FAIL sb_d1_unexpected got=%h exp=none", data_d1);
      end else begin
        e1 = exp_d1.pop_front();
        if (data_d1 !== e1) $display("FAIL sb_d1_data got=%h exp=%h", data_d1, e1);
        else passes++;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    d0_pause = 1'b0;
    d1_pause = 1'b0;
    vc0_q.delete();
    vc1_q.delete();
    exp_d0.delete();
    exp_d1.delete();
    pop_hist.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (!(vc0_q.size() == 0 && vc1_q.size() == 0 && exp_d0.size() == 0 &&
             exp_d1.size() == 0 && idle && !push_d0 && !push_d1) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 1000) $display("FAIL %s_drain got=timeout exp=idle", tag);
    else passes++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    vc0_q.push_back(6'h01);
    vc0_q.push_back(6'h02);
    vc1_q.push_back(6'h13);
    repeat (2) @(negedge clk);
    checks++;
    if ({pop_vc0, pop_vc1, push_d0, push_d1} !== 4'b0000)
      $display("FAIL rst_strobes got=%b exp=0000", {pop_vc0, pop_vc1, push_d0, push_d1});
    else passes++;
    checks++;
    if (d0_count !== 8'h00 || d1_count !== 8'h00)
      $display("FAIL rst_counts got=%h/%h exp=00/00", d0_count, d1_count);
    else passes++;
    checks++;
    if (data_d0 !== 6'h00 || data_d1 !== 6'h00)
      $display("FAIL rst_data got=%h/%h exp=00/00", data_d0, data_d1);
    else passes++;
    checks++;
    if (idle !== 1'b1) $display("FAIL rst_idle got=%b exp=1", idle);
    else passes++;
    reset = 1'b0;
    #1;
    checks++;
    if (pop_vc0 !== 1'b0) $display("FAIL rst_release_pop got=%b exp=0", pop_vc0);
    else passes++;
    @(negedge clk);
    checks++;
    if (pop_vc0 !== 1'b1) $display("FAIL rst_first_pop got=%b exp=1", pop_vc0);
    else passes++;
    drain("reset");
    checks++;
    if (d0_count !== 8'd2 || d1_count !== 8'd1)
      $display("FAIL rst_flow_counts got=%0d/%0d exp=2/1", d0_count, d1_count);
    else passes++;
  endtask

  task automatic test_basic();
    do_reset();
    vc0_q.push_back(6'h10);
    vc0_q.push_back(6'h05);
    #2;
    checks++;
    if (pop_vc0 !== 1'b1) $display("FAIL basic_pop_t got=%b exp=1", pop_vc0);
    else passes++;
    @(negedge clk);
    checks++;
    if (pop_vc0 !== 1'b1) $display("FAIL basic_pop_t1 got=%b exp=1", pop_vc0);
    else passes++;
    @(negedge clk);
    checks++;
    if (push_d1 !== 1'b1 || data_d1 !== 6'h10 || push_d0 !== 1'b0 || pop_vc0 !== 1'b0)
      $display("FAIL basic_t2 got=p1:%b d1:%h p0:%b pop:%b exp=p1:1 d1:10 p0:0 pop:0",
               push_d1, data_d1, push_d0, pop_vc0);
    else passes++;
    @(negedge clk);
    checks++;
    if (push_d0 !== 1'b1 || data_d0 !== 6'h05 || push_d1 !== 1'b0)
      $display("FAIL basic_t3 got=p0:%b d0:%h p1:%b exp=p0:1 d0:05 p1:0",
               push_d0, data_d0, push_d1);
    else passes++;
    checks++;
    if (data_d1 !== 6'h10) $display("FAIL basic_d1_hold got=%h exp=10", data_d1);
    else passes++;
    drain("basic");
    checks++;
    if (d0_count !== 8'd1 || d1_count !== 8'd1)
      $display("FAIL basic_counts got=%0d/%0d exp=1/1", d0_count, d1_count);
    else passes++;
  endtask

  task automatic test_burst();
    int n = 0;
    int exp_pat;
    do_reset();
    for (int i = 0; i < 12; i++) vc0_q.push_back(DW'(i));
    for (int i = 0; i < 6; i++)  vc1_q.push_back(DW'(32 + i));
    while (pop_hist.size() < 10 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (pop_hist.size() < 10) $display("FAIL burst_wait got=%0d exp=10", pop_hist.size());
    else passes++;
    for (int i = 0; i < 10 && i < pop_hist.size(); i++) begin
      exp_pat = ((i % 5) == 4) ? 1 : 0;
      checks++;
      if (pop_hist[i] !== exp_pat)
        $display("FAIL burst_pop[%0d] got=vc%0d exp=vc%0d", i, pop_hist[i], exp_pat);
      else passes++;
    end
    drain("burst");
    checks++;
    if (d0_count !== 8'd18 || d1_count !== 8'd0)
      $display("FAIL burst_counts got=%0d/%0d exp=18/0", d0_count, d1_count);
    else passes++;
  endtask

  task automatic test_pause();
    do_reset();
    vc0_q.push_back(6'h01);
    vc0_q.push_back(6'h12);
    vc0_q.push_back(6'h03);
    vc0_q.push_back(6'h14);
    @(posedge clk);
    @(posedge clk);
    #1;
    d0_pause = 1'b1;
    #1;
    checks++;
    if (pop_vc0 !== 1'b0) $display("FAIL pause_pop_blocked got=%b exp=0", pop_vc0);
    else passes++;
    @(negedge clk);
    checks++;
    if (push_d0 !== 1'b1 || data_d0 !== 6'h01 || pop_vc0 !== 1'b0)
      $display("FAIL pause_inflight0 got=p0:%b d0:%h pop:%b exp=p0:1 d0:01 pop:0",
               push_d0, data_d0, pop_vc0);
    else passes++;
    @(negedge clk);
    checks++;
    if (push_d1 !== 1'b1 || data_d1 !== 6'h12 || pop_vc0 !== 1'b0)
      $display("FAIL pause_inflight1 got=p1:%b d1:%h pop:%b exp=p1:1 d1:12 pop:0",
               push_d1, data_d1, pop_vc0);
    else passes++;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({pop_vc0, push_d0, push_d1} !== 3'b000)
        $display("FAIL pause_quiet got=%b exp=000", {pop_vc0, push_d0, push_d1});
      else passes++;
    end
    checks++;
    if (pop_hist.size() != 2) $display("FAIL pause_pop_count got=%0d exp=2", pop_hist.size());
    else passes++;
    d0_pause = 1'b0;
    #1;
    checks++;
    if (pop_vc0 !== 1'b1) $display("FAIL pause_resume got=%b exp=1", pop_vc0);
    else passes++;
    drain("pause");
    checks++;
    if (d0_count !== 8'd2 || d1_count !== 8'd2)
      $display("FAIL pause_counts got=%0d/%0d exp=2/2", d0_count, d1_count);
    else passes++;
  endtask

  task automatic test_d1_pause_vc1();
    do_reset();
    d1_pause = 1'b1;
    vc1_q.push_back(6'h13);
    vc1_q.push_back(6'h31);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({pop_vc0, pop_vc1} !== 2'b00)
        $display("FAIL d1pause_blocked got=%b exp=00", {pop_vc0, pop_vc1});
      else passes++;
    end
    d1_pause = 1'b0;
    #1;
    checks++;
    if (pop_vc1 !== 1'b1 || pop_vc0 !== 1'b0)
      $display("FAIL d1pause_resume got=%b exp=01", {pop_vc0, pop_vc1});
    else passes++;
    drain("d1pause");
    checks++;
    if (d0_count !== 8'd0 || d1_count !== 8'd2)
      $display("FAIL d1pause_counts got=%0d/%0d exp=0/2", d0_count, d1_count);
    else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    vc0_q.push_back(6'h07);
    vc0_q.push_back(6'h18);
    @(negedge clk);
    reset = 1'b1;
    vc0_q.delete();
    exp_d0.delete();
    exp_d1.delete();
    #1;
    checks++;
    if ({pop_vc0, pop_vc1, push_d0, push_d1} !== 4'b0000 || idle !== 1'b1)
      $display("FAIL rstmid_now got=%b idle=%b exp=0000 idle=1",
               {pop_vc0, pop_vc1, push_d0, push_d1}, idle);
    else passes++;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({push_d0, push_d1} !== 2'b00 || d0_count !== 8'h00 || d1_count !== 8'h00)
        $display("FAIL rstmid_no_push got=%b cnt=%h/%h exp=00 cnt=00/00",
                 {push_d0, push_d1}, d0_count, d1_count);
      else passes++;
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (idle !== 1'b1 || data_d0 !== 6'h00)
      $display("FAIL rstmid_after got=idle:%b d0:%h exp=idle:1 d0:00", idle, data_d0);
    else passes++;
  endtask

  task automatic test_saturation();
    do_reset();
    push0_seen = 0;
    for (int i = 0; i < 260; i++) vc0_q.push_back(DW'(i % 16));
    drain("sat");
    checks++;
    if (push0_seen != 260) $display("FAIL sat_pushes got=%0d exp=260", push0_seen);
    else passes++;
    checks++;
    if (d0_count !== 8'hFF || d1_count !== 8'h00)
      $display("FAIL sat_counts got=%h/%h exp=ff/00", d0_count, d1_count);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_burst();
    test_pause();
    test_d1_pause_vc1();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
